// File: rtl/raiz_cuadrada_axis.sv
// raiz_cuadrada_axis
//   Iterative integer square root on an AXI-stream style handshake. Accepts
//   one unsigned operand x, resolves one root bit per clock with the restoring
//   digit-by-digit method, then presents floor(sqrt(x)) and x - root^2.
//   Only one operand is in flight; latency is ROOT_WIDTH clocks from the
//   input handshake to the first cycle of axis_out_valid.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   axis_in_data    operand x (DATA_WIDTH bits, unsigned)
//   axis_in_valid   operand valid
//   axis_in_ready   high while idle (registered-state decode)
//   axis_out_data   floor(sqrt(x)) (ROOT_WIDTH bits)
//   axis_out_rem    x - root^2 (ROOT_WIDTH+1 bits, range 0..2*root)
//   axis_out_valid  high while a result is held (registered-state decode)
//   axis_out_ready  downstream accepts the result
module raiz_cuadrada_axis #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     axis_in_data,
    input  logic                      axis_in_valid,
    output logic                      axis_in_ready,
    output logic [DATA_WIDTH/2-1:0]   axis_out_data,
    output logic [DATA_WIDTH/2:0]     axis_out_rem,
    output logic                      axis_out_valid,
    input  logic                      axis_out_ready
);

    localparam int unsigned ROOT_WIDTH = DATA_WIDTH / 2;
    localparam int unsigned CNT_W      = (ROOT_WIDTH > 1) ? $clog2(ROOT_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]   op_q;
    logic [ROOT_WIDTH-1:0]   root_q;
    logic [ROOT_WIDTH+1:0]   rem_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [ROOT_WIDTH-1:0]   out_data_q;
    logic [ROOT_WIDTH:0]     out_rem_q;

    logic                    accept;
    logic                    last_iter;

    // One restoring step. rem_q never exceeds 2^ROOT_WIDTH before the shift,
    // so the shifted value always fits in ROOT_WIDTH+2 bits.
    logic [ROOT_WIDTH+1:0]   r_shift;
    logic [ROOT_WIDTH+1:0]   trial;
    logic [ROOT_WIDTH+1:0]   diff;
    logic                    ge;
    logic [ROOT_WIDTH+1:0]   rem_next;
    logic [ROOT_WIDTH-1:0]   root_next;

    always_comb begin
        r_shift   = (rem_q << 2) | {{ROOT_WIDTH{1'b0}}, op_q[DATA_WIDTH-1 -: 2]};
        trial     = {root_q, 2'b01};
        diff      = r_shift - trial;
        ge        = (r_shift >= trial);
        rem_next  = ge ? diff : r_shift;
        root_next = {root_q[ROOT_WIDTH-2:0], ge};
    end

    assign accept    = (state_q == IDLE) && axis_in_valid;
    assign last_iter = (state_q == BUSY) && (cnt_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (axis_in_valid)  state_d = BUSY;
            BUSY:    if (cnt_q == '0)    state_d = DONE;
            DONE:    if (axis_out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes
    always_comb begin
        axis_in_ready  = (state_q == IDLE);
        axis_out_valid = (state_q == DONE);
    end

    // Iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            op_q   <= axis_in_data;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= CNT_W'(ROOT_WIDTH - 1);
        end else if (state_q == BUSY) begin
            op_q   <= op_q << 2;
            root_q <= root_next;
            rem_q  <= rem_next;
            cnt_q  <= cnt_q - 1'b1;
        end
    end

    // Result registers are captured on the final iteration and persist past
    // DONE so the working registers are free for the next operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_rem_q  <= '0;
        end else if (last_iter) begin
            out_data_q <= root_next;
            out_rem_q  <= rem_next[ROOT_WIDTH:0];
        end
    end

    assign axis_out_data = out_data_q;
    assign axis_out_rem  = out_rem_q;

endmodule

// File: doc/raiz_cuadrada_axis.md
Name: raiz_cuadrada_axis

Overview:
Iterative integer square-root stage placed directly downstream of the sum-of-squares accumulator. It consumes one accumulated sum per AXI-stream beat and returns floor(sqrt(x)) plus the remainder x - root^2, giving the L2 norm of the original packet. It uses a digit-by-digit (restoring) binary algorithm that resolves one root bit per clock. Only one operand is in flight at a time.

Parameters:
DATA_WIDTH, 32, width of the input operand; must be even and >= 4.
ROOT_WIDTH, DATA_WIDTH/2, width of the root output; derived, not overridden.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
axis_in_data  input  DATA_WIDTH  unsigned operand x (the accumulated sum of squares).
axis_in_valid  input  1  operand valid.
axis_in_ready  output  1  block can accept an operand.
axis_out_data  output  ROOT_WIDTH  floor(sqrt(x)).
axis_out_rem  output  ROOT_WIDTH+1  x - root^2, range 0..2*root.
axis_out_valid  output  1  result valid.
axis_out_ready  input  1  downstream accepts the result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, BUSY, DONE.
- Reset (synchronous, rst=1 at a rising edge): state goes to IDLE and the iteration counter, operand, root and remainder registers go to 0.
- Reset outputs: axis_in_ready=1, axis_out_valid=0, axis_out_data=0, axis_out_rem=0.
- Reset mid-BUSY or mid-DONE aborts the operation and discards the result; no output beat is produced.
- axis_in_ready = (state==IDLE). axis_out_valid = (state==DONE). Both are registered-state decodes with no combinational path from any input.
- IDLE -> BUSY on the edge where axis_in_valid && axis_in_ready.
  - At that edge: operand register <= axis_in_data, root <= 0, partial remainder <= 0, counter <= ROOT_WIDTH-1.
- BUSY: one iteration per edge, for exactly ROOT_WIDTH edges.
  - Shift the top two operand bits into the remainder: r' = (r<<2) | op[MSB:MSB-1]. Then shift the operand left by 2.
  - Trial value t = (root<<2) | 1.
  - If r' >= t: r <= r' - t and root <= (root<<1) | 1. Otherwise r <= r' and root <= root<<1.
  - The counter decrements each edge. On the edge where the counter is 0, go to DONE.
- Latency: if the input handshake occurs at edge k, axis_out_valid is first high after edge k+ROOT_WIDTH (k+16 for the default).
- DONE: axis_out_data and axis_out_rem hold stable while axis_out_valid=1 and axis_out_ready=0 (arbitrary backpressure).
  - DONE -> IDLE on the edge where axis_out_ready=1.
  - The next operand cannot be accepted until the edge after that, so minimum initiation interval is ROOT_WIDTH+2 cycles.
- Input changes during BUSY or DONE are ignored. axis_in_valid may be held high without effect.
- Width rules:
  - Internal remainder register is ROOT_WIDTH+2 bits to hold r' without overflow.
  - The output remainder is truncated to ROOT_WIDTH+1 bits; this truncation is lossless because the remainder is always <= 2*root.
  - All arithmetic is unsigned.
- Boundaries:
  - x=0 gives root=0, rem=0 with the same latency.
  - x = 2^DATA_WIDTH-1 gives root = 2^ROOT_WIDTH-1 and rem = 2^(ROOT_WIDTH+1)-2, with no overflow.
  - Latency is data-independent.
- Output registers keep the last result after DONE -> IDLE, until the next DONE overwrites them. Downstream must qualify with axis_out_valid.

Test Plan:
- Reset, then x=0 handshake at edge k -> axis_out_valid rises after edge k+16; out=0, rem=0; axis_in_ready=0 from edge k+1 until the edge after the output handshake.
- Sequence x=1, 15, 16, 1000000, with axis_out_ready tied high -> (1,0), (3,6), (4,0), (1000,0); consecutive input handshakes exactly 18 cycles apart.
- x=0xFFFFFFFF -> out=65535 (0xFFFF), rem=131070 (0x1FFFE).
- x=50, with axis_out_ready held low for 10 cycles after valid -> out=7, rem=1 held stable for all 10 cycles; axis_in_ready stays 0; one beat transferred when ready rises.
- Assert rst for one edge mid-BUSY (8 cycles after accepting x=99) -> axis_out_valid never asserts for x=99; axis_in_ready=1 the next cycle; a new x=81 yields out=9, rem=0.
- Random sweep of 1000 operands against a floor(sqrt) model with random ready and valid gaps -> root^2 <= x < (root+1)^2 and rem = x - root^2 every beat; no beat lost or duplicated.
